// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants: register-file geometry, ABI register indices
// and the write-request bundle carried from writeback into the register file.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd1;
    localparam reg_addr_t REG_SP   = 5'd2;
    localparam reg_addr_t REG_GP   = 5'd3;

    typedef struct packed {
        logic            en;
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

    // x0 is hardwired, so a write to it is dropped before it reaches storage.
    function automatic logic wr_effective(input logic en, input reg_addr_t addr);
        return en && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: index decode, x0 forced to zero,
// and optional same-cycle forwarding of the in-flight write.
module reg_read_port
    import riscv_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter bit BYPASS = 1'b0
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     regs [NUM_REGS],
    input  logic                  fwd_vld,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0]     fwd_data,
    output logic [DATA_W-1:0]     data
);

    logic              fwd_hit;
    logic [DATA_W-1:0] stored;

    always_comb begin
        stored  = '0;
        fwd_hit = fwd_vld && (fwd_addr == addr) && (addr != REG_ZERO);
        if (addr != REG_ZERO) begin
            stored = regs[addr];
        end
        data = (BYPASS && fwd_hit) ? fwd_data : stored;
    end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: x1..x31 in flops, x0 reads zero, two operand read
// ports plus a never-forwarded debug port; one write per rising edge.
module reg_file
    import riscv_pkg::*;
#(
    parameter int              DATA_W   = XLEN,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_03FC,
    parameter bit              BYPASS   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    logic [DATA_W-1:0] regs_q    [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_d    [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_view [NUM_REGS];
    wr_req_t           wr;
    logic              fwd_vld;

    always_comb begin
        wr.en   = wr_effective(reg_write, rd_addr);
        wr.addr = rd_addr;
        wr.data = rd_data;
        // A write that reset is about to discard must not be forwarded either.
        fwd_vld = wr.en && rst_n;
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr.en && (wr.addr == REG_ADDR_W'(i))) begin
                regs_d[i] = wr.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        regs_view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rs1 (
        .addr     (rs1_addr),
        .regs     (regs_view),
        .fwd_vld  (fwd_vld),
        .fwd_addr (wr.addr),
        .fwd_data (wr.data),
        .data     (rs1_data)
    );

    reg_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rs2 (
        .addr     (rs2_addr),
        .regs     (regs_view),
        .fwd_vld  (fwd_vld),
        .fwd_addr (wr.addr),
        .fwd_data (wr.data),
        .data     (rs2_data)
    );

    reg_read_port #(.DATA_W(DATA_W), .BYPASS(1'b0)) u_dbg (
        .addr     (dbg_addr),
        .regs     (regs_view),
        .fwd_vld  (fwd_vld),
        .fwd_addr (wr.addr),
        .fwd_data (wr.data),
        .data     (dbg_data)
    );

endmodule
